// File: rtl/mau_pkg.sv
// mau_pkg: shared encodings and types for the memory access unit.
// Optional feature macro: MISALIGN_TRAP_EN (see mem_access_unit.sv).
package mau_pkg;

  // Load codes from the controller.
  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LBU  = 3'b010;
  localparam logic [2:0] LD_LH   = 3'b011;
  localparam logic [2:0] LD_LHU  = 3'b100;
  localparam logic [2:0] LD_LW   = 3'b101;

  // Store codes from the controller.
  localparam logic [1:0] SV_NONE = 2'b00;
  localparam logic [1:0] SV_SB   = 2'b01;
  localparam logic [1:0] SV_SH   = 2'b10;
  localparam logic [1:0] SV_SW   = 2'b11;

  // Width of the bus timeout counter (BUS_TIMEOUT is 1..255).
  localparam int TMO_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 110/111 are illegal load codes and never start an access.
  function automatic logic ld_legal(input logic [2:0] ld);
    return (ld >= LD_LB) && (ld <= LD_LW);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-wide request/acknowledge data memory bus.
// master = load/store unit, slave = memory.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mau_load_align.sv
// mau_load_align: picks the addressed byte/half out of a read word and
// sign- or zero-extends it according to the load code.
module mau_load_align
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  ld,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane extraction (little-endian) followed by extension.
  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (ld)
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'h0, byte_sel};
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'h0, half_sel};
      LD_LW:   result = word;
      default: result = 32'h0;  // stores and non-loads return zero
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the core and a variable-latency
// word memory bus. IDLE -> REQ -> DONE handshake; the core is stalled from
// the request cycle until DONE.
// Optional feature macro: MISALIGN_TRAP_EN -- traps misaligned half/word
// accesses without a bus cycle and adds the misalign output.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic [2:0]  LD,
  input  logic [1:0]  SV,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        bus_err,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  mem_access_unit_if.master bus
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(BUS_TIMEOUT);

  state_t           state;
  logic [2:0]       ld_q;
  logic [1:0]       off_q;
  logic [TMO_W-1:0] cnt;

  logic        is_load;
  logic        legal;
  logic [1:0]  off;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic        we_n;
  logic [31:0] load_res;

  // A valid load code takes priority; a store is only used when no valid
  // load is present.
  assign is_load = ld_legal(LD);
  assign legal   = req_valid & (is_load | (SV != SV_NONE));
  assign off     = addr[1:0];

  // Combinational so the core freezes in the very cycle it presents the access.
  assign stall = ((state == ST_IDLE) & legal) | (state == ST_REQ);

  // Byte-enable and lane-replicated store data for the incoming access.
  always_comb begin
    be_n = 4'b1111;
    wd_n = 32'h0;
    we_n = 1'b0;
    if (!is_load) begin
      we_n = 1'b1;
      case (SV)
        SV_SB: begin
          be_n = 4'b0001 << off;
          wd_n = {4{wdata[7:0]}};
        end
        SV_SH: begin
          be_n = off[1] ? 4'b1100 : 4'b0011;
          wd_n = {2{wdata[15:0]}};
        end
        default: begin
          be_n = 4'b1111;
          wd_n = wdata;
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_n;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  always_comb begin
    mis_n = 1'b0;
    if (is_load)
      mis_n = (((LD == LD_LH) | (LD == LD_LHU)) & addr[0]) |
              ((LD == LD_LW) & (off != 2'b00));
    else
      mis_n = ((SV == SV_SH) & addr[0]) |
              ((SV == SV_SW) & (off != 2'b00));
  end
`endif

  mau_load_align u_align (
    .word   (bus.mem_rdata),
    .off    (off_q),
    .ld     (ld_q),
    .result (load_res)
  );

  // Access FSM with registered bus and result outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      ld_q          <= LD_NONE;
      off_q         <= 2'b00;
      cnt           <= '0;
      rdata         <= 32'h0;
      done          <= 1'b0;
      bus_err       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'b0000;
      bus.mem_addr  <= 30'h0;
      bus.mem_wdata <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      misalign      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (legal) begin
            ld_q    <= is_load ? LD : LD_NONE;
            off_q   <= off;
            cnt     <= '0;
            rdata   <= 32'h0;
            bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            if (mis_n) begin
              // Trap without touching the bus.
              misalign <= 1'b1;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              misalign      <= 1'b0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= we_n;
              bus.mem_be    <= be_n;
              bus.mem_addr  <= addr[31:2];
              bus.mem_wdata <= wd_n;
              state         <= ST_REQ;
            end
`else
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= we_n;
            bus.mem_be    <= be_n;
            bus.mem_addr  <= addr[31:2];
            bus.mem_wdata <= wd_n;
            state         <= ST_REQ;
`endif
          end
        end
        ST_REQ: begin
          if (bus.mem_ack) begin
            // Ack beats a coincident timeout.
            rdata       <= load_res;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else if (cnt + TMO_W'(1) == TMO_LIM) begin
            cnt         <= cnt + TMO_W'(1);
            rdata       <= 32'h0;
            bus_err     <= 1'b1;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + TMO_W'(1);
          end
        end
        ST_DONE: begin
          // Flags are only meaningful alongside done.
          bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          misalign <= 1'b0;
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit (BUS_TIMEOUT=4).
// Honors MISALIGN_TRAP_EN when defined.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic [2:0]  LD;
  logic [1:0]  SV;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        bus_err;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  mem_access_unit_if bus ();

  mem_access_unit #(.BUS_TIMEOUT(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .LD        (LD),
    .SV        (SV),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .done      (done),
    .bus_err   (bus_err),
`ifdef MISALIGN_TRAP_EN
    .misalign  (misalign),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        bus_err;
    logic        mis;
    logic [3:0]  be;
    logic [29:0] maddr;
    logic [31:0] mwdata;
    logic        we;
  } exp_t;

  typedef struct {
    logic [3:0]  be;
    logic [29:0] maddr;
    logic [31:0] mwdata;
    logic        we;
  } obs_t;

  exp_t exp_q[$];

  // ---------------- reference model ----------------
  function automatic bit ref_is_load(input logic [2:0] ld);
    return ld inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] ld, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> (off * 8);
    b  = sh[7:0];
    h  = (off >= 2) ? w[31:16] : w[15:0];
    case (ld)
      3'd1:    return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      3'd2:    return {24'h0, b};
      3'd3:    return h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'd4:    return {16'h0, h};
      3'd5:    return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] ld, input logic [1:0] sv,
                                        input logic [1:0] off);
    if (ref_is_load(ld)) return 4'hF;
    if (sv == 2'd1) return (off == 0) ? 4'h1 : (off == 1) ? 4'h2 : (off == 2) ? 4'h4 : 4'h8;
    if (sv == 2'd2) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] sv, input logic [31:0] wd);
    if (sv == 2'd1) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (sv == 2'd2) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  function automatic bit ref_mis(input logic [2:0] ld, input logic [1:0] sv,
                                 input logic [1:0] off);
`ifdef MISALIGN_TRAP_EN
    if (ref_is_load(ld))
      return ((ld == 3'd3 || ld == 3'd4) && off[0]) || (ld == 3'd5 && off != 0);
    return (sv == 2'd2 && off[0]) || (sv == 2'd3 && off != 0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- one access with a behavioral memory ----------------
  // Called at a negedge. ack is given after 'waits' REQ cycles (if ack_en).
  task automatic run_access(input logic [2:0] ld, input logic [1:0] sv,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rw, input int waits, input bit ack_en,
                            output int stall_cyc, output int req_cyc, output int lat,
                            output obs_t obs);
    exp_t e;
    exp_t g;
    bit   ld_ok;
    ld_ok    = ref_is_load(ld);
    e.mis    = ref_mis(ld, sv, a[1:0]);
    e.bus_err = !ack_en && !e.mis;
    e.rdata  = (e.mis || !ack_en || !ld_ok) ? 32'h0 : ref_load(ld, a[1:0], rw);
    e.be     = ref_be(ld, sv, a[1:0]);
    e.maddr  = a[31:2];
    e.mwdata = ref_wd(sv, wd);
    e.we     = !ld_ok;
    exp_q.push_back(e);

    obs = '{be: 4'h0, maddr: 30'h0, mwdata: 32'h0, we: 1'b0};
    stall_cyc = 0; req_cyc = 0; lat = -1;
    req_valid = 1'b1; LD = ld; SV = sv; addr = a; wdata = wd;
    #1;
    if (stall) stall_cyc++;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      if (done) begin
        lat = c;
        g = exp_q.pop_front();
        checks++;
        if (rdata !== g.rdata) begin
          errors++;
          $display("FAIL rdata: got %h expected %h (ld=%0d sv=%0d addr=%h)", rdata, g.rdata, ld, sv, a);
        end
        checks++;
        if (bus_err !== g.bus_err) begin
          errors++;
          $display("FAIL bus_err: got %b expected %b", bus_err, g.bus_err);
        end
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL stall_at_done: got %b expected 0", stall);
        end
`ifdef MISALIGN_TRAP_EN
        checks++;
        if (misalign !== g.mis) begin
          errors++;
          $display("FAIL misalign: got %b expected %b", misalign, g.mis);
        end
`endif
        if (g.mis) begin
          checks++;
          if (req_cyc != 0) begin
            errors++;
            $display("FAIL mis_no_req: got %0d req cycles expected 0", req_cyc);
          end
        end
      end else begin
        if (stall) stall_cyc++;
        if (bus.mem_req) begin
          req_cyc++;
          if (req_cyc == 1) begin
            obs = '{be: bus.mem_be, maddr: bus.mem_addr, mwdata: bus.mem_wdata, we: bus.mem_we};
            checks++;
            if (bus.mem_be !== e.be || bus.mem_addr !== e.maddr || bus.mem_we !== e.we) begin
              errors++;
              $display("FAIL bus_fields: got be=%b addr=%h we=%b expected be=%b addr=%h we=%b",
                       bus.mem_be, bus.mem_addr, bus.mem_we, e.be, e.maddr, e.we);
            end
            if (e.we) begin
              checks++;
              if (bus.mem_wdata !== e.mwdata) begin
                errors++;
                $display("FAIL mem_wdata: got %h expected %h", bus.mem_wdata, e.mwdata);
              end
            end
          end
          if (ack_en && req_cyc > waits) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rw;
          end
        end
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within 40 cycles (ld=%0d sv=%0d)", ld, sv);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    req_valid = 1'b0; LD = LD_NONE; SV = SV_NONE;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; LD = LD_NONE; SV = SV_NONE;
    addr = 32'h0; wdata = 32'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (rdata !== 32'h0 || done !== 1'b0 || bus_err !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_core: got rdata=%h done=%b bus_err=%b stall=%b expected all 0",
               rdata, done, bus_err, stall);
    end
    checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0 ||
        bus.mem_addr !== 30'h0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got req=%b we=%b be=%b addr=%h wd=%h expected all 0",
               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sb();
    int s, r, l; obs_t o;
    run_access(LD_NONE, SV_SB, 32'h0000_0013, 32'h0000_00A5, 32'h0, 0, 1, s, r, l, o);
    checks++;
    if (o.be !== 4'b1000 || o.mwdata !== 32'hA5A5A5A5 || o.maddr !== 30'h4) begin
      errors++;
      $display("FAIL sb_lanes: got be=%b wd=%h addr=%h expected be=1000 wd=a5a5a5a5 addr=4",
               o.be, o.mwdata, o.maddr);
    end
    checks++;
    if (l != 2) begin
      errors++;
      $display("FAIL sb_latency: got %0d expected 2", l);
    end
    @(negedge clk);
  endtask

  task automatic test_loads();
    int s, r, l; obs_t o;
    run_access(LD_LB, SV_NONE, 32'h0000_0202, 32'h0, 32'h0080_0000, 0, 1, s, r, l, o);
    checks++;
    if (rdata !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb: got %h expected ffffff80", rdata);
    end
    @(negedge clk);
    run_access(LD_LBU, SV_NONE, 32'h0000_0202, 32'h0, 32'h0080_0000, 0, 1, s, r, l, o);
    checks++;
    if (rdata !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu: got %h expected 00000080", rdata);
    end
    @(negedge clk);
    run_access(LD_LH, SV_NONE, 32'h0000_0102, 32'h0, 32'h8001_1234, 3, 1, s, r, l, o);
    checks++;
    if (rdata !== 32'hFFFF_8001) begin
      errors++; $display("FAIL lh: got %h expected ffff8001", rdata);
    end
    checks++;
    if (s != 5) begin
      errors++; $display("FAIL lh_stall: got %0d stall cycles expected 5", s);
    end
    @(negedge clk);
    run_access(LD_LHU, SV_NONE, 32'h0000_0100, 32'h0, 32'h8001_F234, 1, 1, s, r, l, o);
    checks++;
    if (rdata !== 32'h0000_F234) begin
      errors++; $display("FAIL lhu: got %h expected 0000f234", rdata);
    end
    @(negedge clk);
    // Load wins over a simultaneous store code.
    run_access(LD_LW, SV_SW, 32'h0000_0040, 32'h1111_2222, 32'hCAFE_F00D, 0, 1, s, r, l, o);
    checks++;
    if (rdata !== 32'hCAFE_F00D || o.we !== 1'b0) begin
      errors++; $display("FAIL load_wins: got rdata=%h we=%b expected cafef00d we=0", rdata, o.we);
    end
    @(negedge clk);
  endtask

  task automatic test_sh();
    int s, r, l; obs_t o;
    run_access(LD_NONE, SV_SH, 32'h0000_0082, 32'hDEAD_BEEF, 32'h0, 0, 1, s, r, l, o);
    checks++;
    if (o.be !== 4'b1100 || o.mwdata !== 32'hBEEF_BEEF || o.we !== 1'b1) begin
      errors++;
      $display("FAIL sh_lanes: got be=%b wd=%h we=%b expected be=1100 wd=beefbeef we=1",
               o.be, o.mwdata, o.we);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int s, r, l; obs_t o; bit extra;
    run_access(LD_NONE, SV_SW, 32'h0000_0040, 32'h1234_5678, 32'h0, 0, 0, s, r, l, o);
    checks++;
    if (r != 4) begin
      errors++; $display("FAIL timeout_req_cycles: got %0d expected 4", r);
    end
    extra = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mem_req) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++; $display("FAIL timeout_no_more_req: got mem_req after timeout expected none");
    end
  endtask

  task automatic test_misalign();
    int s, r, l; obs_t o;
    run_access(LD_LW, SV_NONE, 32'h0000_0006, 32'h0, 32'h1357_9BDF, 0, 1, s, r, l, o);
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (r != 0 || rdata !== 32'h0) begin
      errors++; $display("FAIL misalign_lw: got req=%0d rdata=%h expected 0 and 0", r, rdata);
    end
`else
    // Offset bits are ignored: full word from word address 1.
    checks++;
    if (rdata !== 32'h1357_9BDF || o.maddr !== 30'h1) begin
      errors++; $display("FAIL lw_offset_ignored: got rdata=%h addr=%h expected 13579bdf addr=1",
                         rdata, o.maddr);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_illegal();
    bit seen;
    req_valid = 1'b1; LD = 3'b110; SV = SV_NONE; addr = 32'h10;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL illegal_stall: got %b expected 0", stall);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.mem_req || done) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL illegal_no_access: got req/done activity expected none");
    end
    req_valid = 1'b0; LD = LD_NONE;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int s, r, l; obs_t o;
    run_access(LD_NONE, SV_SW, 32'h0000_0100, 32'hA0B0_C0D0, 32'h0, 0, 1, s, r, l, o);
    // Next request presented while DONE: accepted after one IDLE cycle.
    run_access(LD_LW, SV_NONE, 32'h0000_0104, 32'h0, 32'h0F0E_0D0C, 0, 1, s, r, l, o);
    checks++;
    if (l != 3 || rdata !== 32'h0F0E_0D0C) begin
      errors++; $display("FAIL back_to_back: got lat=%0d rdata=%h expected 3 0f0e0d0c", l, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_req();
    bit seen;
    req_valid = 1'b1; LD = LD_LW; SV = SV_NONE; addr = 32'h20;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL midreq_start: got mem_req=%b expected 1", bus.mem_req);
    end
    rstn = 1'b0; req_valid = 1'b0; LD = LD_NONE;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midreq_reset: got req=%b done=%b expected 0 0", bus.mem_req, done);
    end
    rstn = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done || bus.mem_req) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL stray_ack: got done/mem_req after stray ack expected none");
    end
  endtask

  task automatic test_random();
    int s, r, l; obs_t o;
    logic [2:0] ld; logic [1:0] sv;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        ld = 3'($urandom_range(5, 1)); sv = 2'($urandom_range(3, 0));
      end else begin
        ld = LD_NONE; sv = 2'($urandom_range(3, 1));
      end
      run_access(ld, sv, $urandom, $urandom, $urandom, $urandom_range(2, 0), 1, s, r, l, o);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_loads();
    test_sh();
    test_timeout();
    test_misalign();
    test_illegal();
    test_back_to_back();
    test_reset_mid_req();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
